// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Burst lock is compiled in with FIFO_ARB_BURST_EN.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_req);
    return (ptr >= num_req - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// scanning upward and wrapping from NUM_REQ-1 to 0.
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  int               sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    sum    = 0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = IDX_W'(sum);
      if (!found && req[cand]) begin
        found        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// Define FIFO_ARB_BURST_EN to hold a grant for up to BURST_LEN words.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] w_data_in,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_w_data,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;

  logic               owner_req, accept, last_word, release_own;
  logic [IDX_W-1:0]   next_ptr, pick_ptr, pick_idx;
  logic [NUM_REQ-1:0] owner_mask, pick_mask, pick_onehot;
  logic               pick_found;

`ifdef FIFO_ARB_BURST_EN
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign last_word = (cnt_q == CNT_W'(BURST_LEN - 1));
`else
  assign last_word = 1'b1;
`endif

  assign owner_req   = req[owner_q];
  assign owner_mask  = NUM_REQ'(1) << owner_q;
  assign accept      = (state_q == ARB_OWN) && owner_req && !fifo_full;
  assign release_own = (state_q == ARB_OWN) && (!owner_req || (accept && last_word));
  assign next_ptr    = IDX_W'(rr_next(32'(owner_q), NUM_REQ));

  // The releasing owner is masked out so a handoff never re-grants it the same cycle.
  assign pick_mask = (state_q == ARB_OWN) ? (req & ~owner_mask) : req;
  assign pick_ptr  = (state_q == ARB_OWN) ? next_ptr : rr_ptr_q;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (pick_mask),
    .ptr    (pick_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  assign ack         = accept ? owner_mask : '0;
  assign fifo_wr     = accept;
  assign fifo_w_data = (state_q == ARB_OWN) ? w_data_in[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign grant       = grant_q;
  assign busy        = busy_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
`ifdef FIFO_ARB_BURST_EN
    cnt_d    = cnt_q;
`endif
    if (state_q == ARB_IDLE || release_own) begin
      if (release_own) rr_ptr_d = next_ptr;
      if (pick_found) begin
        state_d = ARB_OWN;
        owner_d = pick_idx;
        grant_d = pick_onehot;
        busy_d  = 1'b1;
`ifdef FIFO_ARB_BURST_EN
        cnt_d   = '0;
`endif
      end else begin
        state_d = ARB_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    end
`ifdef FIFO_ARB_BURST_EN
    else if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
`ifdef FIFO_ARB_BURST_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
`ifdef FIFO_ARB_BURST_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed-vector bench for fifo_wr_arbiter; expectations follow FIFO_ARB_BURST_EN.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int PULSE_IDX  = 3;

  logic                          clk = 1'b0;
  logic                          reset;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] w_data_in;
  logic                          fifo_full;
  logic [NUM_REQ-1:0]            ack;
  logic [NUM_REQ-1:0]            grant;
  logic                          fifo_wr;
  logic [DATA_WIDTH-1:0]         fifo_w_data;
  logic                          busy;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [3:0] req;
    logic       full;
    logic [3:0] expAck;
    logic [3:0] expGrant;
    logic       expBusy;
    logic [7:0] expData;
  } vec_t;

  vec_t vecs[$];

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .BURST_LEN(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .w_data_in   (w_data_in),
    .fifo_full   (fifo_full),
    .ack         (ack),
    .grant       (grant),
    .fifo_wr     (fifo_wr),
    .fifo_w_data (fifo_w_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t row(input logic [3:0] r, input logic f, input logic [3:0] a,
                               input logic [3:0] g, input logic b, input logic [7:0] d);
    vec_t v;
    v.req = r; v.full = f; v.expAck = a; v.expGrant = g; v.expBusy = b; v.expData = d;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic f);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req       = r;
    fifo_full = f;
  endtask

  task automatic checkAll(input string pfx, input vec_t v);
    checkOutput({pfx, " ack"},   32'(ack),         32'(v.expAck));
    checkOutput({pfx, " grant"}, 32'(grant),       32'(v.expGrant));
    checkOutput({pfx, " busy"},  32'(busy),        32'(v.expBusy));
    checkOutput({pfx, " wr"},    32'(fifo_wr),     32'(|v.expAck));
    checkOutput({pfx, " data"},  32'(fifo_w_data), 32'(v.expData));
  endtask

  initial begin
    // Producer data: p0=A5, p1=3C, p2=5A, p3=C3
    w_data_in = 32'hC3_5A_3C_A5;
    reset     = 1'b1;
    req       = '0;
    fifo_full = 1'b0;

`ifdef FIFO_ARB_BURST_EN
    vecs.push_back(row(4'h3, 0, 4'h0, 4'h0, 0, 8'h00));
    for (int i = 1; i <= 3; i++) vecs.push_back(row(4'h3, 0, 4'h1, 4'h1, 1, 8'hA5));
    for (int i = 4; i <= 7; i++) vecs.push_back(row(4'h3, 0, 4'h1, 4'h1, 1, 8'hA5));
    vecs.push_back(row(4'h3, 0, 4'h2, 4'h2, 1, 8'h3C));
    vecs.push_back(row(4'h3, 0, 4'h2, 4'h2, 1, 8'h3C));
    vecs.push_back(row(4'h3, 1, 4'h0, 4'h2, 1, 8'h3C));
    vecs.push_back(row(4'h3, 1, 4'h0, 4'h2, 1, 8'h3C));
    vecs.push_back(row(4'h3, 0, 4'h2, 4'h2, 1, 8'h3C));
    vecs.push_back(row(4'h3, 0, 4'h2, 4'h2, 1, 8'h3C));
    vecs.push_back(row(4'h3, 0, 4'h1, 4'h1, 1, 8'hA5));
    vecs.push_back(row(4'h0, 0, 4'h0, 4'h1, 1, 8'hA5));
`else
    vecs.push_back(row(4'hF, 0, 4'h0, 4'h0, 0, 8'h00));
    vecs.push_back(row(4'hF, 0, 4'h1, 4'h1, 1, 8'hA5));
    vecs.push_back(row(4'hF, 0, 4'h2, 4'h2, 1, 8'h3C));
    vecs.push_back(row(4'hF, 0, 4'h4, 4'h4, 1, 8'h5A));
    vecs.push_back(row(4'hF, 0, 4'h1, 4'h1, 1, 8'hA5));
    vecs.push_back(row(4'h0, 0, 4'h0, 4'h2, 1, 8'h3C));
    vecs.push_back(row(4'h1, 0, 4'h0, 4'h0, 0, 8'h00));
    vecs.push_back(row(4'h1, 0, 4'h1, 4'h1, 1, 8'hA5));
    vecs.push_back(row(4'h4, 1, 4'h0, 4'h0, 0, 8'h00));
    vecs.push_back(row(4'h4, 1, 4'h0, 4'h4, 1, 8'h5A));
    vecs.push_back(row(4'h4, 0, 4'h4, 4'h4, 1, 8'h5A));
    vecs.push_back(row(4'h8, 1, 4'h0, 4'h0, 0, 8'h00));
    vecs.push_back(row(4'h8, 1, 4'h0, 4'h8, 1, 8'hC3));
    vecs.push_back(row(4'h4, 0, 4'h0, 4'h8, 1, 8'hC3));
    vecs.push_back(row(4'h4, 0, 4'h4, 4'h4, 1, 8'h5A));
    vecs.push_back(row(4'h0, 0, 4'h0, 4'h0, 0, 8'h00));
`endif

    #12;
    checkOutput("rst grant", 32'(grant),       32'h0);
    checkOutput("rst busy",  32'(busy),        32'h0);
    checkOutput("rst ack",   32'(ack),         32'h0);
    checkOutput("rst wr",    32'(fifo_wr),     32'h0);
    checkOutput("rst data",  32'(fifo_w_data), 32'h0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, vecs[i].full);
      @(negedge clk);
      checkAll($sformatf("c%0d", i), vecs[i]);
      if (i == PULSE_IDX) begin
        // Asynchronous reset mid-grant must clear outputs without a clock edge
        #1 reset = 1'b1;
        #1;
        checkOutput("pulse grant", 32'(grant),   32'h0);
        checkOutput("pulse busy",  32'(busy),    32'h0);
        checkOutput("pulse wr",    32'(fifo_wr), 32'h0);
        #1 reset = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
